pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//   Parametrised, pipelined multi-bit add/subtract unit for the gate-level arithmetic library.
//   Operands are split into STAGE_BITS-wide slices; the carry ripples one slice per clock.
//   Accepts one operation per cycle and returns the result STAGES cycles later.
//   A valid/ready handshake on both sides lets it sit between producer and consumer blocks.
//   Outputs are sum, carry-out and signed overflow.
// PARAMETERS
//   WIDTH       16  operand/sum width in bits; must be a multiple of STAGE_BITS
//   STAGE_BITS   4  bits summed per pipeline stage; STAGES = WIDTH/STAGE_BITS (>=1)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      A/B/C/SUB hold a valid operation
//   in_ready   out  1      unit accepts an operation this cycle
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   C          in   1      carry-in (SUB=0) / borrow-in (SUB=1)
//   SUB        in   1      0: S=A+B+C   1: S=A-B-C
//   out_valid  out  1      S/CO/OVF hold a valid result
//   out_ready  in   1      consumer takes the result this cycle
//   S          out  WIDTH  sum/difference, modulo 2^WIDTH
//   CO         out  1      carry-out; for SUB=1, 1 means no borrow
//   OVF        out  1      two's-complement signed overflow
// BEHAVIOUR
//   Arithmetic: Beff = SUB ? ~B : B; cin0 = SUB ? ~C : C; {CO,S} = A + Beff + cin0.
//     OVF = carry into bit WIDTH-1 XOR CO.
//   Stage k (0..STAGES-1) adds slice [k*STAGE_BITS +: STAGE_BITS] with the carry registered by stage k-1.
//     Stage 0 uses cin0.
//     Each stage register holds: valid bit, carry, finished low sum slices, unprocessed high A/Beff slices.
//   Transfer: in fires when in_valid & in_ready; out fires when out_valid & out_ready.
//   Latency: an op accepted at edge N appears on S/CO/OVF with out_valid=1 after edge N+STAGES.
//     With no stall this is exactly STAGES cycles. Throughput is 1 op/cycle.
//   Stall (global): stall = out_valid & ~out_ready.
//     in_ready = ~stall (combinational from out_valid/out_ready only; never from in_valid).
//     While stalled, every stage register holds, including bubbles.
//     S/CO/OVF/out_valid stay stable until the result is taken.
//   Bubbles: when not stalled and in_valid=0, a stage-0 valid bit of 0 enters the pipe.
//     Data in bubble slots is don't-care, but S/CO/OVF must not change while out_valid=0.
//     Last-stage data registers load only on a valid slot.
//   Reset: every valid bit clears; S=0, CO=0, OVF=0, out_valid=0, in_ready=1 on the cycle after rst.
//     In-flight operations are discarded (reset mid-operation = flush, no partial result).
//     rst overrides stall and in_valid.
//   Edge cases:
//     STAGES=1 is a single registered adder with latency 1.
//     Simultaneous in-fire and out-fire in the same cycle is legal and loses nothing.
//     Wrap-around: S is modulo 2^WIDTH and the carry is reported only on CO.
//     C is carry-in for an add and borrow-in for a subtract, per the Arithmetic rule.
//   Assertion (sim only): WIDTH % STAGE_BITS == 0, else $error at time 0.
// TESTING (WIDTH=16, STAGE_BITS=4, latency 4)
//   Add with carry ripple across all slices:
//     A=0x00FF B=0x0001 C=0 SUB=0 -> 4 cycles later S=0x0100 CO=0 OVF=0 out_valid=1.
//   Unsigned wrap: A=0xFFFF B=0x0001 C=0 -> S=0x0000 CO=1 OVF=0.
//   Signed overflow on subtract: A=0x8000 B=0x0001 C=0 SUB=1 -> S=0x7FFF CO=1 OVF=1.
//     Also A=0x0000 B=0x0001 SUB=1 -> S=0xFFFF CO=0 (borrow).
//   Back-to-back stream: 8 ops on consecutive cycles with out_ready=1 -> 8 results on 8 consecutive
//     cycles, in order, each matching the reference model.
//   Backpressure: hold out_ready=0 for 5 cycles once the first result is valid.
//     Expect in_ready=0 throughout, S stable, no op lost or duplicated; the stream resumes in order.
//   Reset mid-operation: assert rst 2 cycles after accepting 3 ops.
//     Next cycle out_valid=0, S=0, in_ready=1; no stale result emerges in the following 6 cycles.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit. Operands are split into STAGE_BITS-wide
// slices; each pipeline stage adds one slice and hands its carry to the
// next stage, so the carry ripples one slice per clock. A global stall
// (result valid but not taken) freezes the whole pipe, bubbles included.

// One slice of the ripple: STAGE_BITS-wide add with carry in/out.
module pipelined_adder_slice #(
    parameter int STAGE_BITS = 4
) (
    input  logic [STAGE_BITS-1:0] a,
    input  logic [STAGE_BITS-1:0] b,
    input  logic                  cin,
    output logic [STAGE_BITS-1:0] s,
    output logic                  cout
);
    logic [STAGE_BITS:0] t;

    // Extend by one bit so the slice carry-out falls out of the add.
    assign t    = {1'b0, a} + {1'b0, b} + {{STAGE_BITS{1'b0}}, cin};
    assign s    = t[STAGE_BITS-1:0];
    assign cout = t[STAGE_BITS];
endmodule

module pipelined_adder #(
    parameter int WIDTH      = 16,
    parameter int STAGE_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OVF
);
    localparam int STAGES = WIDTH / STAGE_BITS;
    localparam int L      = STAGES - 1;

    if ((WIDTH % STAGE_BITS) != 0 || WIDTH < STAGE_BITS) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGE_BITS");
    end

    logic                               stall;
    logic                               in_fire;

    // Stage inputs: stage 0 sees the ports, stage k sees register k-1.
    logic [STAGES-1:0]                  vld_in;
    logic [STAGES-1:0][WIDTH-1:0]       a_in, b_in, s_in;
    logic [STAGES-1:0]                  c_in;

    // Per-stage slice results and the sum with that slice filled in.
    logic [STAGES-1:0][STAGE_BITS-1:0]  slice_s;
    logic [STAGES-1:0]                  slice_c;
    logic [STAGES-1:0][WIDTH-1:0]       s_nx;

    // Stage registers; register L is the output register.
    logic [STAGES-1:0]                  vld_pipe;
    logic [STAGES-1:0][WIDTH-1:0]       a_q, b_q, s_q;
    logic [STAGES-1:0]                  c_q;

    // Only the MSBs of the last stage's operands feed OVF; the rest of
    // those bits are carried along because it keeps every stage identical.
    logic                               unused_last;

    assign stall     = vld_pipe[L] & ~out_ready;
    assign in_ready  = ~stall;
    assign in_fire   = in_valid & ~stall;

    // Route ports into stage 0 (with subtract inversion) and each register
    // into the following stage.
    always_comb begin
        vld_in = '0;
        a_in   = '0;
        b_in   = '0;
        s_in   = '0;
        c_in   = '0;
        vld_in[0] = in_fire;
        a_in[0]   = A;
        b_in[0]   = SUB ? ~B : B;
        c_in[0]   = SUB ? ~C : C;
        for (int k = 1; k < STAGES; k++) begin
            vld_in[k] = vld_pipe[k-1];
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            s_in[k]   = s_q[k-1];
            c_in[k]   = c_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipelined_adder_slice #(.STAGE_BITS(STAGE_BITS)) u_slice (
            .a    (a_in[k][k*STAGE_BITS +: STAGE_BITS]),
            .b    (b_in[k][k*STAGE_BITS +: STAGE_BITS]),
            .cin  (c_in[k]),
            .s    (slice_s[k]),
            .cout (slice_c[k])
        );
    end

    // Merge each stage's new slice into the partial sum it carries.
    always_comb begin
        s_nx = s_in;
        for (int k = 0; k < STAGES; k++) begin
            s_nx[k][k*STAGE_BITS +: STAGE_BITS] = slice_s[k];
        end
    end

    // Advance the pipe unless stalled; the output register only takes
    // valid slots so S/CO/OVF stay put across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            c_q      <= '0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_pipe[k] <= vld_in[k];
                if (k < L || vld_in[k]) begin
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                    s_q[k] <= s_nx[k];
                    c_q[k] <= slice_c[k];
                end
            end
        end
    end

    assign out_valid = vld_pipe[L];
    assign S         = s_q[L];
    assign CO        = c_q[L];
    // Carry into the MSB is a^b^s at that bit; overflow when it differs from CO.
    assign OVF       = a_q[L][WIDTH-1] ^ b_q[L][WIDTH-1] ^ s_q[L][WIDTH-1] ^ c_q[L];
    assign unused_last = ^{a_q[L], b_q[L]};
endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized and directed bench for pipelined_adder (16 bits, 4 stages).
module tb_pipelined_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, C, SUB, out_valid, out_ready, CO, OVF;
    logic [W-1:0] A, B, S;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_out  = 0;
    logic [17:0] exp_q[$];
    int          out_cyc[$];

    logic         skip = 1'b1;
    logic         prev_stall = 1'b0, prev_valid = 1'b0;
    logic [W-1:0] prev_s;
    logic         prev_co, prev_ovf;
    bit           rnd_on;

    pipelined_adder #(.WIDTH(W), .STAGE_BITS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .C(C), .SUB(SUB),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .CO(CO), .OVF(OVF)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, packed as {ovf, co, s}.
    function automatic logic [17:0] ref_op(input logic [W-1:0] a, b, input logic c, sub);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int ci = int'(c);
        int r, sr;
        logic co, ovf;
        if (!sub) begin
            r  = ua + ub + ci;
            co = (r > 65535);
            sr = sa + sb + ci;
        end else begin
            r  = ua - ub - ci;
            co = (r >= 0);
            sr = sa - sb - ci;
        end
        ovf = (sr > 32767) || (sr < -32768);
        return {ovf, co, r[15:0]};
    endfunction

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [17:0] e;
        cyc++;
        if (rst) begin
            exp_q.delete();
            skip = 1'b1;
        end else begin
            chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (!skip && prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_S", S, prev_s);
                chk("stall_CO", CO, prev_co);
                chk("stall_OVF", OVF, prev_ovf);
            end
            if (!skip && !prev_valid && !out_valid) begin
                chk("bubble_S", S, prev_s);
                chk("bubble_CO", CO, prev_co);
                chk("bubble_OVF", OVF, prev_ovf);
            end
            if (out_valid && out_ready) begin
                chk("unexpected_out", exp_q.size() == 0, 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("S", S, e[15:0]);
                    chk("CO", CO, e[16]);
                    chk("OVF", OVF, e[17]);
                    out_cyc.push_back(cyc);
                    n_out++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_op(A, B, C, SUB));
            skip = 1'b0;
        end
        prev_stall = out_valid && !out_ready;
        prev_valid = out_valid;
        prev_s     = S;
        prev_co    = CO;
        prev_ovf   = OVF;
    end

    task automatic send(input logic [W-1:0] a, b, input logic c, sub);
        bit ok = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; A = a; B = b; C = c; SUB = sub;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        chk("send_timeout", ok, 1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        chk(tag, exp_q.size(), 0);
    endtask

    // Single op, then check it arrives exactly 4 cycles after it was presented.
    task automatic directed(input logic [W-1:0] a, b, input logic c, sub,
                            input logic [W-1:0] es, input logic eco, eovf);
        send(a, b, c, sub);
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lat_early", out_valid, 0);
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
        chk("dir_S", S, es);
        chk("dir_CO", CO, eco);
        chk("dir_OVF", OVF, eovf);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners[4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        if ($urandom_range(3) == 0) return corners[$urandom_range(3)];
        return W'($urandom);
    endfunction

    initial begin
        int n0;
        bit found;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; C = 1'b0; SUB = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_S", S, 0);
        chk("rst_CO", CO, 0);
        chk("rst_OVF", OVF, 0);
        chk("rst_in_ready", in_ready, 1);

        directed(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        directed(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        drain("dir_drain");

        // Back-to-back stream of 8 ops.
        @(posedge clk);
        out_cyc.delete();
        n0 = n_out;
        for (int i = 0; i < 8; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
        idle();
        drain("b2b_drain");
        chk("b2b_count", n_out - n0, 8);
        chk("b2b_consecutive", out_cyc[7] - out_cyc[0], 7);

        // Backpressure: 5 stalled cycles once the first result shows up.
        n0 = n_out;
        found = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
                idle();
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk); #1;
                    if (out_valid) begin found = 1; break; end
                end
                chk("bp_first_result", found, 1);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_out_valid", out_valid, 1);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        chk("bp_count", n_out - n0, 8);

        // Reset in the middle of three in-flight ops.
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'h4321, 16'h0101, 1'b1, 1'b1);
        send(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        idle();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_S", S, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        repeat (6) begin
            @(negedge clk);
            chk("mid_rst_no_stale", out_valid, 0);
        end

        // Random traffic with random gaps and random backpressure.
        rnd_on = 1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(3) != 0) send(pick(), pick(), 1'($urandom), 1'($urandom));
                    else idle();
                end
                idle();
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
